// File: rtl/logic_sweep_checker.sv
// Self-test sweeper: walks dut_in through 0..63, holds each vector while the
// function block settles, and compares dut_w against the built-in golden function.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for start
// SETTLE | dut_in driven, waiting SETTLE_CYCLES for dut_w to settle
// CHECK  | one cycle: compare dut_w, log errors, advance or finish
// DONE   | results held; start launches a new sweep
module logic_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [5:0]       dut_in,
    input  logic             dut_w,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [5:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int unsigned    CNT_W       = 8;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic [5:0]       LAST_VEC    = 6'd63;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             exp_w;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    // dut_in doubles as the sweep index; it is only updated on entry to SETTLE
    always_comb begin
        exp_w    = (dut_in[5] & dut_in[4]) | (~dut_in[3] & dut_in[2]) | (dut_in[1] ^ dut_in[0]);
        mismatch = (dut_w != exp_w);
        err_next = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_next = err_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            settle_cnt       <= '0;
            dut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        dut_in           <= '0;
                        busy             <= 1'b1;
                        settle_cnt       <= SETTLE_LOAD;
                        state            <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_vec   <= dut_in;
                        first_fail_valid <= 1'b1;
                    end
                    if (dut_in == LAST_VEC) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= S_DONE;
                    end else begin
                        dut_in     <= dut_in + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_SETTLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Bench for logic_sweep_checker: emulated function block with injectable faults,
// table-driven and randomized sweeps, busy-start and mid-sweep reset sequences.
module tb_logic_sweep_checker;

    localparam int LATENCY = 64 * 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  dut_in;
    logic        dut_w;
    logic        busy, done, pass, first_fail_valid;
    logic [6:0]  err_count;
    logic [5:0]  first_fail_vec;

    logic        stuck_en = 1'b0;
    logic        stuck_val = 1'b0;
    logic [63:0] fault_mask = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic golden(input logic [5:0] v);
        return (v[5] & v[4]) | (~v[3] & v[2]) | (v[1] ^ v[0]);
    endfunction

    // emulated function block: golden, stuck, or golden with per-vector flips
    assign dut_w = stuck_en ? stuck_val : (golden(dut_in) ^ fault_mask[dut_in]);

    logic_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(7)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dut_in(dut_in),
        .dut_w(dut_w),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_fail_vec(first_fail_vec),
        .first_fail_valid(first_fail_valid)
    );

    typedef struct {
        string       name;
        logic        stuck_en;
        logic        stuck_val;
        logic [63:0] mask;
        bit          noisy;
        int          exp_err;
        int          exp_first;
        int          exp_valid;
        int          exp_pass;
    } case_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // reference: count mismatches over the whole vector space in order
    task automatic model(input case_t c, output int err, output int first, output int valid,
                         output int ok);
        err = 0; first = 0; valid = 0;
        for (int v = 0; v < 64; v++) begin
            logic ret;
            ret = c.stuck_en ? c.stuck_val : (golden(6'(v)) ^ c.mask[v]);
            if (ret != golden(6'(v))) begin
                if (valid == 0) begin
                    first = v;
                    valid = 1;
                end
                err = (err < 127) ? err + 1 : err;
            end
        end
        ok = (err == 0) ? 1 : 0;
    endtask

    task automatic run_sweep(input case_t c);
        int         cyc;
        int         hist[64];
        logic [5:0] prev;
        bit         order_ok;
        bit         hold_ok;
        stuck_en   = c.stuck_en;
        stuck_val  = c.stuck_val;
        fault_mask = c.mask;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({c.name, " busy_at_start"}, 32'(busy), 32'd1);
        check({c.name, " cleared_at_start"}, {done, pass, first_fail_valid, err_count}, 32'd0);
        check({c.name, " first_vec_zero"}, 32'(dut_in), 32'd0);
        foreach (hist[i]) hist[i] = 0;
        prev = dut_in;
        order_ok = 1'b1;
        cyc = 0;
        while (!done && cyc < 1000) begin
            if (cyc < LATENCY) hist[dut_in]++;
            if (dut_in != prev && dut_in != 6'(prev + 6'd1)) order_ok = 1'b0;
            prev = dut_in;
            start = c.noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        hold_ok = order_ok;
        foreach (hist[i]) if (hist[i] != 3) hold_ok = 1'b0;
        check({c.name, " latency"}, 32'(cyc), 32'(LATENCY));
        check({c.name, " busy_at_end"}, 32'(busy), 32'd0);
        check({c.name, " vector_hold_order"}, 32'(hold_ok), 32'd1);
        check({c.name, " err_count"}, 32'(err_count), 32'(c.exp_err));
        check({c.name, " first_fail_valid"}, 32'(first_fail_valid), 32'(c.exp_valid));
        check({c.name, " first_fail_vec"}, 32'(first_fail_vec), 32'(c.exp_first));
        check({c.name, " pass"}, 32'(pass), 32'(c.exp_pass));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " dut_in"}, 32'(dut_in), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " pass"}, 32'(pass), 32'd0);
        check({tag, " err_count"}, 32'(err_count), 32'd0);
        check({tag, " first_fail_vec"}, 32'(first_fail_vec), 32'd0);
        check({tag, " first_fail_valid"}, 32'(first_fail_valid), 32'd0);
    endtask

    initial begin
        case_t table_cases[5];
        case_t rc;
        logic [63:0] m37;
        int e, f, vld, ok;

        m37 = 64'd1 << 37;
        table_cases[0] = '{"golden",   1'b0, 1'b0, 64'd0, 1'b0,  0,  0, 0, 1};
        table_cases[1] = '{"stuck0",   1'b1, 1'b0, 64'd0, 1'b0, 46,  1, 1, 0};
        table_cases[2] = '{"stuck1",   1'b1, 1'b1, 64'd0, 1'b0, 18,  0, 1, 0};
        table_cases[3] = '{"inverted", 1'b0, 1'b0, '1,    1'b0, 64,  0, 1, 0};
        table_cases[4] = '{"fault37",  1'b0, 1'b0, m37,   1'b1,  1, 37, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) run_sweep(table_cases[i]);

        for (int i = 0; i < 6; i++) begin
            rc.name      = $sformatf("random%0d", i);
            rc.stuck_en  = 1'b0;
            rc.stuck_val = 1'b0;
            rc.noisy     = (i % 2) == 1;
            case (i % 3)
                0: rc.mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                1: rc.mask = {$urandom, $urandom};
                default: rc.mask = 64'd1 << $urandom_range(0, 63);
            endcase
            model(rc, e, f, vld, ok);
            rc.exp_err = e; rc.exp_first = f; rc.exp_valid = vld; rc.exp_pass = ok;
            run_sweep(rc);
        end

        // mid-sweep reset with errors already logged, then a clean sweep
        fault_mask = 64'd1 << 5;
        stuck_en   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("midsweep err_logged", 32'(err_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midsweep_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(table_cases[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
